// File: rtl/blockade_pkg.sv
// blockade_pkg: shared types and joystick bit indices for the Blockade input conditioner.
package blockade_pkg;
    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [1:0] {IDLE, PULSE, LOCK} coin_state_t;
    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_COIN  = 4;
    localparam int JOY_START = 5;
    // One-hot mask of a direction in joystick bit positions; NONE maps to 0.
    function automatic logic [3:0] dir_mask(dir_t d);
        return d == DIR_UP    ? 4'(1 << JOY_UP)    :
               d == DIR_DOWN  ? 4'(1 << JOY_DOWN)  :
               d == DIR_LEFT  ? 4'(1 << JOY_LEFT)  :
               d == DIR_RIGHT ? 4'(1 << JOY_RIGHT) : 4'b0000;
    endfunction
endpackage

// File: rtl/blockade_4way.sv
// blockade_4way: per-player 4-way stick resolver; the first-pressed direction wins a diagonal.
// Only built when BLOCKADE_4WAY_EN is defined.
`ifdef BLOCKADE_4WAY_EN
module blockade_4way
    import blockade_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] raw,
    output logic [3:0] dir_n
);
    dir_t dir, dir_d;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) dir <= DIR_NONE;
        else          dir <= dir_d;

    always_comb
        dir_d = raw == 4'b0000         ? DIR_NONE :
                |(raw & dir_mask(dir)) ? dir      :
                raw[JOY_UP]            ? DIR_UP   :
                raw[JOY_DOWN]          ? DIR_DOWN :
                raw[JOY_LEFT]          ? DIR_LEFT : DIR_RIGHT;

    assign dir_n = ~dir_mask(dir);
endmodule
`endif

// File: rtl/blockade_inputs.sv
// blockade_inputs: joystick/DIP conditioner producing the active-low in0/in1/in2 cabinet ports.
// BLOCKADE_4WAY_EN selects 4-way stick resolution; otherwise raw directions pass through.
module blockade_inputs
    import blockade_pkg::*;
#(
    parameter int COIN_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] joy0,
    input  logic [15:0] joy1,
    input  logic [7:0]  dsw,
    input  logic        vblank,
    output logic [7:0]  in0,
    output logic [7:0]  in1,
    output logic [7:0]  in2
);
    coin_state_t state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        vblank_q, coin_q, coin_n_d;
    logic        unused;

    wire coin_raw  = joy0[JOY_COIN] | joy1[JOY_COIN];
    wire coin_rise = coin_raw & ~coin_q;
    wire vb_rise   = vblank & ~vblank_q;

    assign unused = &{1'b0, joy0[15:6], joy1[15:6]};

    // coin_q resets high so a coin held through reset cannot fire a pulse.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            vblank_q <= 1'b0;
            coin_q   <= 1'b1;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            vblank_q <= vblank;
            coin_q   <= coin_raw;
        end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE:
                if (coin_rise) begin
                    state_d = PULSE;
                    cnt_d   = 4'(COIN_FRAMES);
                end
            PULSE:
                if (vb_rise) begin
                    cnt_d   = cnt == 4'd0 ? cnt : cnt - 4'd1;
                    state_d = cnt_d == 4'd0 ? LOCK : PULSE;
                end
            LOCK:
                if (!coin_raw) state_d = IDLE;
            default:
                state_d = IDLE;
        endcase
    end

    always_comb coin_n_d = state_d != PULSE;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            in0 <= 8'hFF;
            in2 <= 8'hFF;
        end else begin
            in0 <= {coin_n_d, ~(joy0[JOY_START] | joy1[JOY_START]), 6'b111111};
            in2 <= ~dsw;
        end

`ifdef BLOCKADE_4WAY_EN
    blockade_4way u_p1 (.clk(clk), .reset_n(reset_n), .raw(joy0[3:0]), .dir_n(in1[3:0]));
    blockade_4way u_p2 (.clk(clk), .reset_n(reset_n), .raw(joy1[3:0]), .dir_n(in1[7:4]));
`else
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) in1 <= 8'hFF;
        else          in1 <= ~{joy1[3:0], joy0[3:0]};
`endif
endmodule

// File: tb/tb_blockade_inputs.sv
// tb_blockade_inputs: randomized and directed checks of blockade_inputs against a behavioural model.
module tb_blockade_inputs;
    localparam int CF = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] joy0 = 16'h003F;
    logic [15:0] joy1 = 16'h0000;
    logic [7:0]  dsw = 8'h5A;
    logic        vblank = 1'b0;
    logic [7:0]  in0, in1, in2;

    blockade_inputs #(.COIN_FRAMES(CF)) dut (
        .clk(clk), .reset_n(reset_n), .joy0(joy0), .joy1(joy1), .dsw(dsw),
        .vblank(vblank), .in0(in0), .in1(in1), .in2(in2)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pulse lasts CF frame starts after the press, then needs a release.
    logic [7:0] exp0 = 8'hFF, exp1 = 8'hFF, exp2 = 8'hFF;
    bit busy = 0, need_rel = 0, prev_c = 1, prev_vb = 0;
    int seen = 0;
    logic [3:0] cur0 = 4'h0, cur1 = 4'h0;

`ifdef BLOCKADE_4WAY_EN
    function automatic logic [3:0] res4(input logic [3:0] cur, input logic [3:0] raw);
        if (raw == 4'h0) return 4'h0;
        if ((cur & raw) != 4'h0) return cur;
        for (int i = 3; i >= 0; i--) if (raw[i]) return 4'(1 << i);
        return 4'h0;
    endfunction
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp0 = 8'hFF; exp1 = 8'hFF; exp2 = 8'hFF;
            busy = 0; need_rel = 0; prev_c = 1; prev_vb = 0; seen = 0;
            cur0 = 4'h0; cur1 = 4'h0;
        end else begin
            bit c, vbr;
            c = joy0[4] | joy1[4];
            vbr = vblank && !prev_vb;
            if (busy) begin
                if (vbr) seen++;
                if (seen == CF) begin busy = 0; need_rel = 1; end
            end else if (need_rel) begin
                if (!c) need_rel = 0;
            end else if (c && !prev_c) begin
                busy = 1; seen = 0;
            end
            prev_c = c;
            prev_vb = vblank;
            exp0 = {!busy, !(joy0[5] | joy1[5]), 6'h3F};
            exp2 = ~dsw;
`ifdef BLOCKADE_4WAY_EN
            cur0 = res4(cur0, joy0[3:0]);
            cur1 = res4(cur1, joy1[3:0]);
            exp1 = ~{cur1, cur0};
`else
            exp1 = ~{joy1[3:0], joy0[3:0]};
`endif
        end
    end

    always @(negedge clk)
        if (checking) begin
            chk("in0", in0, exp0);
            chk("in1", in1, exp1);
            chk("in2", in2, exp2);
        end

    // Pulse bookkeeping from the bench's own view of vblank and coin_n.
    int fc = 0, pulses = 0, rises = 0, last_rises = 0;
    bit vbp = 0, vr = 0, was_low = 0;

    task automatic cyc();
        @(posedge clk);
        vr = vblank && !vbp;
        vbp = vblank;
        if (was_low && vr) rises++;
        #1;
        if (was_low && in0[7]) last_rises = rises;
        if (!was_low && !in0[7]) begin pulses++; rises = 0; end
        was_low = !in0[7];
        fc++;
        vblank = (fc % 8) >= 6;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int p;
        cycn(3);
        checking = 1'b1;
        chk("reset_in0", in0, 8'hFF);
        chk("reset_in1", in1, 8'hFF);
        chk("reset_in2", in2, 8'hFF);
        reset_n = 1'b1;
        cyc();
        chk("dsw_after_reset", in2, 8'hA5);
        chk("held_coin_after_reset", in0, 8'hBF);
        cycn(6);
        chk("held_coin_no_pulse", 8'(pulses), 8'd0);

        joy0 = 16'h0; cycn(4);
        joy1 = 16'h0010; cycn(80);
        chk("pulse_count", 8'(pulses), 8'd1);
        chk("pulse_frames", 8'(last_rises), 8'd3);
        for (int i = 0; i < 6; i++) begin
            joy0[4] = ~joy0[4];
            cycn(3);
        end
        joy0 = 16'h0; cycn(10);
        chk("lock_press_ignored", 8'(pulses), 8'd1);
        joy1 = 16'h0; cycn(3);
        joy1 = 16'h0010; cycn(40);
        chk("repress_pulse", 8'(pulses), 8'd2);
        chk("repress_frames", 8'(last_rises), 8'd3);

        joy1 = 16'h0; cycn(4);
        while (fc % 8 != 5) cyc();
        cyc();
        joy1 = 16'h0010;
        cycn(40);
        chk("coincident_pulse", 8'(pulses), 8'd3);
        chk("coincident_frames", 8'(last_rises), 8'd3);

        joy1 = 16'h0; cycn(3);
        joy0 = 16'h0010; cycn(4);
        chk("midpulse_low", {7'h0, in0[7]}, 8'h00);
        p = pulses;
        #3 reset_n = 1'b0;
        #1 chk("async_reset_in0", in0, 8'hFF);
        cyc();
        reset_n = 1'b1;
        cycn(30);
        chk("no_retrigger", 8'(pulses), 8'(p));
        joy0 = 16'h0; cycn(3);
        joy0 = 16'h0010; cycn(40);
        chk("retrigger_after_release", 8'(pulses), 8'(p + 1));
        joy0 = 16'h0; cycn(3);

`ifdef BLOCKADE_4WAY_EN
        joy0 = 16'h0008; cyc();
        chk("p1_up", {4'h0, in1[3:0]}, 8'h07);
        joy0 = 16'h000A; cycn(3);
        chk("p1_diag_hold", {4'h0, in1[3:0]}, 8'h07);
        joy0 = 16'h0002; cyc();
        chk("p1_left_takeover", {4'h0, in1[3:0]}, 8'h0D);
        joy1 = 16'h0005; cyc();
        chk("p2_down_wins", {4'h0, in1[7:4]}, 8'h0B);
`else
        joy0 = 16'h000A; cyc();
        chk("p1_passthrough", {4'h0, in1[3:0]}, 8'h05);
        joy1 = 16'h0005; cyc();
        chk("p2_passthrough", {4'h0, in1[7:4]}, 8'h0A);
`endif
        joy0 = 16'h0; joy1 = 16'h0; cycn(2);

        for (int i = 0; i < 3000; i++) begin
            cyc();
            if ($urandom % 4 == 0) begin
                joy0 = 16'($urandom);
                joy0[4] = ($urandom % 8) == 0;
            end
            if ($urandom % 4 == 0) begin
                joy1 = 16'($urandom);
                joy1[4] = ($urandom % 8) == 0;
            end
            if ($urandom % 50 == 0) dsw = 8'($urandom);
        end
        cycn(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
